// File: rtl/decode_skid_stage_if.sv
// Handshake bundle for the decode skid stage: fetch-side input channel
// and the decoded-bundle output channel toward execute.
interface decode_skid_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  // Producer of instructions / consumer of decoded bundles
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rs1, out_rs2, out_rd, out_imm, out_fmt, out_illegal
  );

  // The decode stage itself
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rs1, out_rs2, out_rd, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/decode_skid_stage.sv
// Registered RV32I decode stage with a two-entry skid buffer (O = output
// register, S = skid register). in_ready depends only on state and rst so
// the ready path toward fetch is cut.
module decode_skid_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 flush,
  decode_skid_stage_if.slave  bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("decode_skid_stage: XLEN must be 32 or 64");
  end

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_CSR   = 7'b1110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  // The raw word is kept whole: every field is a fixed slice of it.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  entry_t      dec;
  entry_t      blank;
  entry_t      view;
  entry_t      o_q, o_d, s_q, s_d;
  logic        o_valid_q, o_valid_d, s_valid_q, s_valid_d;
  logic        accept, drain;
  logic [31:0] imm32;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;

  // Value shown on the outputs during and right after reset
  always_comb begin
    blank     = '0;
    blank.fmt = FMT_NONE;
  end

  // Combinational decode of the incoming word into an entry
  always_comb begin
    op          = bus.in_instr[6:0];
    f3          = bus.in_instr[14:12];
    f7          = bus.in_instr[31:25];
    imm32       = '0;
    dec         = '0;
    dec.pc      = bus.in_pc;
    dec.instr   = bus.in_instr;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;
    case (op)
      OP_LUI, OP_AUIPC: begin
        dec.fmt = FMT_U;
        imm32   = {bus.in_instr[31:12], 12'h000};
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        imm32   = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                   bus.in_instr[20], bus.in_instr[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_IMM, OP_CSR: begin
        dec.fmt = FMT_I;
        imm32   = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
        if (op == OP_LOAD && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) begin
          dec.illegal = 1'b1;
        end
      end
      OP_STORE: begin
        dec.fmt     = FMT_S;
        imm32       = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
        dec.illegal = (f3 > 3'd2);
      end
      OP_BR: begin
        dec.fmt     = FMT_B;
        imm32       = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                       bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
        dec.illegal = (f3 == 3'd2 || f3 == 3'd3);
      end
      OP_REG: begin
        dec.fmt     = FMT_R;
        dec.illegal = !(f7 == 7'h00 || f7 == 7'h20);
      end
      default: begin
        dec.fmt     = FMT_NONE;
        dec.illegal = 1'b1;
      end
    endcase
    dec.imm = XLEN'($signed(imm32));
  end

  assign accept = bus.in_valid && bus.in_ready;
  assign drain  = o_valid_q && bus.out_ready;

  // Skid-buffer next state: flush beats drain and accept; S always refills O first
  always_comb begin
    o_d       = o_q;
    s_d       = s_q;
    o_valid_d = o_valid_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      o_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (drain) begin
      if (s_valid_q) begin
        o_d       = s_q;
        s_valid_d = 1'b0;
      end else if (accept) begin
        o_d = dec;
      end else begin
        o_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!o_valid_q) begin
        o_d       = dec;
        o_valid_d = 1'b1;
      end else begin
        s_d       = dec;
        s_valid_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset that also blanks the stored data
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q       <= blank;
      s_q       <= blank;
      o_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      o_q       <= o_d;
      s_q       <= s_d;
      o_valid_q <= o_valid_d;
      s_valid_q <= s_valid_d;
    end
  end

  // Outputs read straight from O, forced to the blank value while rst is high
  always_comb begin
    view = rst ? blank : o_q;
  end

  assign bus.in_ready    = !s_valid_q && !rst;
  assign bus.out_valid   = o_valid_q && !rst;
  assign bus.out_pc      = view.pc;
  assign bus.out_opcode  = view.instr[6:0];
  assign bus.out_funct3  = view.instr[14:12];
  assign bus.out_funct7  = view.instr[31:25];
  assign bus.out_rs1     = view.instr[19:15];
  assign bus.out_rs2     = view.instr[24:20];
  assign bus.out_rd      = view.instr[11:7];
  assign bus.out_imm     = view.imm;
  assign bus.out_fmt     = view.fmt;
  assign bus.out_illegal = view.illegal;

endmodule

// File: tb/tb_decode_skid_stage.sv
// Bench for decode_skid_stage: drives an XLEN=64 and an XLEN=32 instance
// with the same stream and compares both against a 2-deep FIFO model.
module tb_decode_skid_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  always #5 clk = ~clk;

  decode_skid_stage_if #(.XLEN(64), .PC_W(32)) bus64 ();
  decode_skid_stage_if #(.XLEN(32), .PC_W(32)) bus32 ();

  assign bus64.in_valid  = in_valid;
  assign bus64.in_instr  = in_instr;
  assign bus64.in_pc     = in_pc;
  assign bus64.out_ready = out_ready;
  assign bus32.in_valid  = in_valid;
  assign bus32.in_instr  = in_instr;
  assign bus32.in_pc     = in_pc;
  assign bus32.out_ready = out_ready;

  decode_skid_stage #(.XLEN(64), .PC_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus64)
  );
  decode_skid_stage #(.XLEN(32), .PC_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus32)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  item_t       model_q[$];
  item_t       pend[$];
  int          total = 0;
  int          passes = 0;
  int          fails = 0;
  bit          after_rst = 1'b0;
  logic [31:0] pc_next = 32'h0000_1000;

  // One comparison: counts it and reports a mismatch
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode straight from the opcode table and immediate layouts
  function automatic void ref_decode(input logic [31:0] i, output logic [2:0] fmt,
                                     output logic [63:0] imm, output logic ill);
    logic [2:0] f3;
    logic [6:0] f7;
    f3  = i[14:12];
    f7  = i[31:25];
    fmt = 3'd7;
    imm = 64'd0;
    ill = 1'b0;
    case (i[6:0])
      7'b0110111, 7'b0010111: begin fmt = 3'd4; imm = {{32{i[31]}}, i[31:12], 12'h000}; end
      7'b1101111: begin fmt = 3'd5; imm = {{44{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; end
      7'b1100111, 7'b0010011, 7'b1110011: begin fmt = 3'd1; imm = {{52{i[31]}}, i[31:20]}; end
      7'b0000011: begin
        fmt = 3'd1; imm = {{52{i[31]}}, i[31:20]};
        ill = (f3 == 3) || (f3 == 6) || (f3 == 7);
      end
      7'b0100011: begin fmt = 3'd2; imm = {{52{i[31]}}, i[31:25], i[11:7]}; ill = (f3 > 2); end
      7'b1100011: begin
        fmt = 3'd3; imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        ill = (f3 == 2) || (f3 == 3);
      end
      7'b0110011: begin fmt = 3'd0; ill = !((f7 == 7'h00) || (f7 == 7'h20)); end
      default: ill = 1'b1;
    endcase
  endfunction

  // Compare both instances against the model head (or the post-reset blank value)
  task automatic checkOutput();
    bit          m_rdy, m_val;
    item_t       it;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic        ill;
    m_rdy = !rst && (model_q.size() < 2);
    m_val = !rst && (model_q.size() > 0);
    chk("in_ready64", {63'd0, bus64.in_ready}, {63'd0, m_rdy});
    chk("out_valid64", {63'd0, bus64.out_valid}, {63'd0, m_val});
    chk("in_ready32", {63'd0, bus32.in_ready}, {63'd0, m_rdy});
    chk("out_valid32", {63'd0, bus32.out_valid}, {63'd0, m_val});
    if (m_val) begin
      it = model_q[0];
      ref_decode(it.instr, fmt, imm, ill);
      chk("pc", {32'd0, bus64.out_pc}, {32'd0, it.pc});
      chk("opcode", {57'd0, bus64.out_opcode}, {57'd0, it.instr[6:0]});
      chk("funct3", {61'd0, bus64.out_funct3}, {61'd0, it.instr[14:12]});
      chk("funct7", {57'd0, bus64.out_funct7}, {57'd0, it.instr[31:25]});
      chk("rs1", {59'd0, bus64.out_rs1}, {59'd0, it.instr[19:15]});
      chk("rs2", {59'd0, bus64.out_rs2}, {59'd0, it.instr[24:20]});
      chk("rd", {59'd0, bus64.out_rd}, {59'd0, it.instr[11:7]});
      chk("imm64", bus64.out_imm, imm);
      chk("fmt", {61'd0, bus64.out_fmt}, {61'd0, fmt});
      chk("illegal", {63'd0, bus64.out_illegal}, {63'd0, ill});
      chk("pc32", {32'd0, bus32.out_pc}, {32'd0, it.pc});
      chk("imm32", {32'd0, bus32.out_imm}, {32'd0, imm[31:0]});
      chk("fmt32", {61'd0, bus32.out_fmt}, {61'd0, fmt});
      chk("illegal32", {63'd0, bus32.out_illegal}, {63'd0, ill});
    end else if (rst || after_rst) begin
      chk("rst_pc", {32'd0, bus64.out_pc}, 64'd0);
      chk("rst_opcode", {57'd0, bus64.out_opcode}, 64'd0);
      chk("rst_rd", {59'd0, bus64.out_rd}, 64'd0);
      chk("rst_imm64", bus64.out_imm, 64'd0);
      chk("rst_fmt", {61'd0, bus64.out_fmt}, 64'd7);
      chk("rst_illegal", {63'd0, bus64.out_illegal}, 64'd0);
      chk("rst_imm32", {32'd0, bus32.out_imm}, 64'd0);
      chk("rst_fmt32", {61'd0, bus32.out_fmt}, 64'd7);
    end
  endtask

  // Check, then advance one clock and update the FIFO model
  task automatic cycle();
    bit    acc, drn;
    item_t tmp;
    #1;
    checkOutput();
    acc = in_valid && !rst && (model_q.size() < 2);
    drn = !rst && (model_q.size() > 0) && out_ready;
    @(posedge clk);
    if (rst || flush) begin
      model_q.delete();
    end else begin
      if (drn) tmp = model_q.pop_front();
      if (acc) begin
        tmp.instr = in_instr;
        tmp.pc    = in_pc;
        model_q.push_back(tmp);
      end
    end
    if (acc) tmp = pend.pop_front();
    after_rst = rst;
    @(negedge clk);
  endtask

  // Present the next pending instruction (if enabled) and run one cycle
  task automatic applyStimulus(input bit v, input bit r, input bit f);
    in_valid  = v && (pend.size() > 0);
    if (pend.size() > 0) begin
      in_instr = pend[0].instr;
      in_pc    = pend[0].pc;
    end else begin
      in_instr = $urandom();
      in_pc    = $urandom();
    end
    out_ready = r;
    flush     = f;
    cycle();
  endtask

  task automatic addInstr(input logic [31:0] i);
    item_t it;
    it.instr = i;
    it.pc    = pc_next;
    pend.push_back(it);
    pc_next += 32'd4;
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    logic [6:0]  ops [10];
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
            7'b0010011, 7'b1110011, 7'b0100011, 7'b1100011, 7'b0110011};
    r = $urandom();
    if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 9)];
    if ($urandom_range(0, 1) == 0) r[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
    return r;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    @(negedge clk);

    // Reset, then the first idle cycle after it
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    rst = 1'b0;
    applyStimulus(0, 1, 0);

    // addi x1,x2,-1
    addInstr(32'hFFF10093);
    applyStimulus(1, 1, 0);
    chk("addi_imm32", {32'd0, bus32.out_imm}, 64'h0000_0000_FFFF_FFFF);
    chk("addi_rd", {59'd0, bus64.out_rd}, 64'd1);
    chk("addi_fmt", {61'd0, bus64.out_fmt}, 64'd1);

    // beq x0,x0,-4 followed back-to-back by lui x5,0x80000
    addInstr(32'hFE000EE3);
    addInstr(32'h800002B7);
    applyStimulus(1, 1, 0);
    chk("beq_imm64", bus64.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_fmt", {61'd0, bus64.out_fmt}, 64'd3);
    applyStimulus(1, 1, 0);
    chk("lui_imm64", bus64.out_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui_rd", {59'd0, bus64.out_rd}, 64'd5);
    applyStimulus(0, 1, 0);

    // Backpressure: A, B, C offered while the consumer stalls
    addInstr(32'h00A00513);
    addInstr(32'h00B00593);
    addInstr(32'h00C00613);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    chk("bp_in_ready", {63'd0, bus64.in_ready}, 64'd0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    for (int k = 0; k < 4; k++) applyStimulus(1, 1, 0);

    // Flush with both entries full and a new input offered
    addInstr(32'h00100693);
    addInstr(32'h00200713);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    addInstr(32'h00300793);
    applyStimulus(1, 0, 1);
    chk("flush_out_valid", {63'd0, bus64.out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, bus64.in_ready}, 64'd1);
    // Flush while the pending input is accepted: it must be discarded
    applyStimulus(1, 1, 1);
    chk("flush_discard", {63'd0, bus64.out_valid}, 64'd0);
    applyStimulus(0, 1, 0);

    // Illegal encodings and a spread of legal formats
    addInstr(32'h00000000);
    applyStimulus(1, 1, 0);
    chk("zero_illegal", {63'd0, bus64.out_illegal}, 64'd1);
    chk("zero_fmt", {61'd0, bus64.out_fmt}, 64'd7);
    addInstr(32'h02000033);
    addInstr(32'h00003003);
    addInstr(32'h00003023);
    addInstr(32'h00002063);
    addInstr(32'h40000033);
    addInstr(32'h00000073);
    addInstr(32'h80000EEF);
    addInstr(32'hFE112E23);
    addInstr(32'h00000067);
    for (int k = 0; k < 12; k++) applyStimulus(1, 1, 0);

    // Random stream with random backpressure, occasional flush, one reset pulse
    for (int c = 0; c < 600; c++) begin
      if (pend.size() < 3) addInstr(randInstr());
      rst = (c == 300);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 24) == 0);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) applyStimulus(0, 1, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
